pll_lock_sequencer: RTL and testbench
=====================================

# pll_lock_sequencer

Parametrised clock-lock supervisor and reset sequencer for the PLL wrappers. It runs on the PLL reference clock and drives the PLL reset. It qualifies the PLL lock with a filter, retries the PLL on lock timeout, and releases NUM_DOMAINS downstream resets in a staged order. It sits between the board reset and every PLL-derived clock domain. It is the supervisory layer the bare PLL wrapper lacks.

## Interface
- NUM_DOMAINS, 3: number of staged reset outputs (1..16).
- RESET_PULSE, 16: cycles pll_reset is held high per PLL reset attempt (≥1).
- LOCK_FILTER, 256: consecutive high lock samples required to qualify lock (≥1).
- LOCK_TIMEOUT, 65536: cycles allowed in WAIT_LOCK before a retry (> LOCK_FILTER).
- STAGE_GAP, 8: cycles between consecutive rst_out releases (≥1).
- MAX_RETRY, 4: consecutive timeouts before entering FAIL (≥1).
- clkin  input  1  reference clock; the only clock.
- reset  input  1  synchronous, active-high reset.
- pll_lock  input  1  raw PLL lock, asynchronous; 2-flop synchronised internally (lock_s).
- pll_reset  output  1  reset to PLL primitive, active-high.
- locked  output  1  qualified lock.
- rst_out  output  NUM_DOMAINS  per-domain resets, active-high; bit 0 released first.
- retry_cnt  output  8  consecutive timeout count, cleared on reaching RUN.
- loss_cnt  output  8  lock-loss events since reset, saturating at 255.
- fail  output  1  sticky; MAX_RETRY consecutive timeouts occurred.

## Operation
- Counter widths: $clog2 of the largest bound each counter must reach, plus one bit.
- Reset values:
  - pll_reset=1, locked=0, rst_out=all ones, retry_cnt=0, loss_cnt=0, fail=0.
  - State is PLL_RST, all counters are 0, and the synchroniser flops are 0.
- PLL_RST: pll_reset=1 and rst_out all ones. After RESET_PULSE cycles, go to WAIT_LOCK with the filter and timeout counters cleared.
- WAIT_LOCK:
  - pll_reset=0.
  - The filter counter increments while lock_s=1 and clears on any lock_s=0 sample.
  - The timeout counter increments every cycle.
  - When the filter reaches LOCK_FILTER: locked=1, go to RELEASE.
  - When the timeout reaches LOCK_TIMEOUT: retry_cnt+1. If the new value equals MAX_RETRY, go to FAIL; otherwise go to PLL_RST.
  - If lock qualification and timeout occur in the same cycle, lock qualification wins.
- RELEASE:
  - rst_out[0] clears on entry.
  - rst_out[i] clears STAGE_GAP cycles after rst_out[i-1] clears.
  - After rst_out[NUM_DOMAINS-1] clears, go to RUN and set retry_cnt=0.
- RUN: hold. All rst_out=0 and locked=1.
- Lock loss (any lock_s=0 sample in RELEASE or RUN):
  - On the next edge: rst_out=all ones, locked=0, loss_cnt+1 (saturating), go to PLL_RST.
  - Glitches are not filtered here; one low sample is a loss.
- FAIL:
  - pll_reset=1, rst_out all ones, locked=0, fail=1.
  - Only reset exits FAIL; pll_lock is ignored.
- Reset asserted in any state returns all outputs to their reset values on the next edge, mid-stage included.
- rst_out bits never deassert out of order. A bit, once cleared, stays cleared until the next loss or reset; then all bits reassert together.

## Timing
- All outputs are registered; there is no combinational path from an input to an output.
- pll_lock to lock_s latency is 2 cycles.
- pll_reset rises the cycle after reset is sampled high. It stays high exactly RESET_PULSE cycles after reset is released.
- locked and rst_out[0] change on the same edge.
- Release spacing is exactly STAGE_GAP cycles per bit.
- Lock-loss reaction is 3 cycles from the pll_lock fall to rst_out all ones: 2 synchroniser cycles plus 1 registered cycle.
- retry_cnt updates on the same edge as the PLL_RST or FAIL transition.
- fail asserts on the same edge as the FAIL transition.

## Test plan
Parameters for all scenarios: NUM_DOMAINS=3, RESET_PULSE=4, LOCK_FILTER=8, LOCK_TIMEOUT=40, STAGE_GAP=2, MAX_RETRY=3.
- Clean bring-up, pll_lock=1 throughout:
  - pll_reset is high 4 cycles after reset is released.
  - locked and rst_out[0] fall/rise 8 cycles after the first lock_s=1 in WAIT_LOCK.
  - rst_out[1] clears 2 cycles after rst_out[0]; rst_out[2] clears 4 cycles after rst_out[0].
  - retry_cnt=0.
- Chattering lock: pll_lock toggles every 5 cycles for 30 cycles, then holds 1.
  - The filter never qualifies during chatter.
  - locked rises 8 cycles after the final stable high reaches lock_s.
  - No timeout occurs.
- Timeout retry and fail: pll_lock=0 throughout.
  - Three PLL_RST pulses of 4 cycles each.
  - retry_cnt steps 1, 2, 3.
  - fail=1 after the third timeout.
  - pll_reset stays high and fail persists until reset.
- Loss in RUN: drop pll_lock for 1 cycle.
  - Exactly 3 cycles later, rst_out=3'b111 and locked=0.
  - loss_cnt=1.
  - A new 4-cycle pll_reset pulse follows, then full re-sequencing.
- Loss mid-RELEASE: drop pll_lock after rst_out[0] clears.
  - rst_out returns to 3'b111 with no out-of-order bit observed.
  - loss_cnt increments.
- Reset mid-RELEASE and saturation:
  - Reset asserted with rst_out=3'b100 yields all reset values on the next edge.
  - After 300 forced losses, loss_cnt reads 255.

Source files
------------

// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer
// Clock-lock supervisor and staged reset sequencer. It runs on the PLL
// reference clock. It pulses the PLL reset and qualifies the PLL lock with a
// run-length filter. If lock does not qualify in time, it retries the PLL, and
// it gives up (sticky fail) after MAX_RETRY consecutive timeouts. Once lock is
// qualified, it releases the downstream domain resets one at a time, lowest
// bit first.
//
// Ports:
//   clkin      reference clock, the only clock
//   reset      synchronous active-high reset
//   pll_lock   raw PLL lock (asynchronous, synchronised internally)
//   pll_reset  reset to the PLL primitive, active-high
//   locked     qualified lock
//   rst_out    per-domain resets, active-high, bit 0 released first
//   retry_cnt  consecutive lock-timeout count, cleared on reaching RUN
//   loss_cnt   lock-loss events since reset, saturating at 255
//   fail       sticky, set after MAX_RETRY consecutive timeouts
module pll_lock_sequencer #(
  parameter int NUM_DOMAINS  = 3,
  parameter int RESET_PULSE  = 16,
  parameter int LOCK_FILTER  = 256,
  parameter int LOCK_TIMEOUT = 65536,
  parameter int STAGE_GAP    = 8,
  parameter int MAX_RETRY    = 4
) (
  input  logic                   clkin,
  input  logic                   reset,
  input  logic                   pll_lock,
  output logic                   pll_reset,
  output logic                   locked,
  output logic [NUM_DOMAINS-1:0] rst_out,
  output logic [7:0]             retry_cnt,
  output logic [7:0]             loss_cnt,
  output logic                   fail
);

  localparam int PW = $clog2(RESET_PULSE) + 1;
  localparam int FW = $clog2(LOCK_FILTER) + 1;
  localparam int TW = $clog2(LOCK_TIMEOUT) + 1;
  localparam int GW = $clog2(STAGE_GAP) + 1;

  localparam logic [PW-1:0]          PULSE_LAST  = PW'(RESET_PULSE - 1);
  localparam logic [FW-1:0]          FILTER_MAX  = FW'(LOCK_FILTER);
  localparam logic [TW-1:0]          TIMEOUT_MAX = TW'(LOCK_TIMEOUT);
  localparam logic [GW-1:0]          GAP_MAX     = GW'(STAGE_GAP);
  localparam logic [7:0]             RETRY_MAX   = 8'(MAX_RETRY);
  localparam logic [NUM_DOMAINS-1:0] ALL_ONES    = '1;

  typedef enum logic [2:0] {
    PLL_RST,
    WAIT_LOCK,
    RELEASE,
    RUN,
    FAIL
  } state_t;

  state_t                   state_q, state_d;
  logic [1:0]               sync_q;
  logic                     lockS;
  logic [PW-1:0]            pulse_q, pulse_d;
  logic [FW-1:0]            filter_q, filter_d, filterInc;
  logic [TW-1:0]            timeout_q, timeout_d, timeoutInc;
  logic [GW-1:0]            gap_q, gap_d, gapInc;
  logic                     pllReset_q, pllReset_d;
  logic                     locked_q, locked_d;
  logic [NUM_DOMAINS-1:0]   rstOut_q, rstOut_d, rstShift;
  logic [7:0]               retry_q, retry_d, retryInc;
  logic [7:0]               loss_q, loss_d;
  logic                     fail_q, fail_d;

  assign lockS = sync_q[1];

  // Next-state and next-output logic. Every output is computed here as a
  // next value and registered below, so no input reaches an output
  // combinationally. Staged release is a left shift of rst_out that brings in
  // zeros, so bits can only clear from bit 0 upward.
  always_comb begin
    state_d    = state_q;
    pulse_d    = pulse_q;
    filter_d   = filter_q;
    timeout_d  = timeout_q;
    gap_d      = gap_q;
    pllReset_d = pllReset_q;
    locked_d   = locked_q;
    rstOut_d   = rstOut_q;
    retry_d    = retry_q;
    loss_d     = loss_q;
    fail_d     = fail_q;
    filterInc  = lockS ? filter_q + 1'b1 : '0;
    timeoutInc = timeout_q + 1'b1;
    gapInc     = gap_q + 1'b1;
    retryInc   = retry_q + 8'd1;
    rstShift   = rstOut_q << 1;

    case (state_q)
      PLL_RST: begin
        if (pulse_q == PULSE_LAST) begin
          state_d    = WAIT_LOCK;
          pllReset_d = 1'b0;
          filter_d   = '0;
          timeout_d  = '0;
        end else begin
          pulse_d = pulse_q + 1'b1;
        end
      end

      // Lock qualification is tested first so it wins a tie with the timeout.
      WAIT_LOCK: begin
        filter_d  = filterInc;
        timeout_d = timeoutInc;
        if (filterInc == FILTER_MAX) begin
          locked_d = 1'b1;
          rstOut_d = ALL_ONES << 1;
          gap_d    = '0;
          if (NUM_DOMAINS == 1) begin
            state_d = RUN;
            retry_d = '0;
          end else begin
            state_d = RELEASE;
          end
        end else if (timeoutInc == TIMEOUT_MAX) begin
          retry_d    = retryInc;
          pllReset_d = 1'b1;
          pulse_d    = '0;
          if (retryInc == RETRY_MAX) begin
            state_d = FAIL;
            fail_d  = 1'b1;
          end else begin
            state_d = PLL_RST;
          end
        end
      end

      // A single low lock sample in RELEASE or RUN counts as a loss.
      RELEASE, RUN: begin
        if (!lockS) begin
          state_d    = PLL_RST;
          pllReset_d = 1'b1;
          pulse_d    = '0;
          locked_d   = 1'b0;
          rstOut_d   = ALL_ONES;
          if (loss_q != 8'hFF) begin
            loss_d = loss_q + 8'd1;
          end
        end else if (state_q == RELEASE) begin
          if (gapInc == GAP_MAX) begin
            gap_d    = '0;
            rstOut_d = rstShift;
            if (rstShift == '0) begin
              state_d = RUN;
              retry_d = '0;
            end
          end else begin
            gap_d = gapInc;
          end
        end
      end

      FAIL: begin
        state_d = FAIL;
      end

      default: begin
        state_d = PLL_RST;
      end
    endcase
  end

  // State, counters, synchroniser and registered outputs. Reset is sampled
  // on the clock edge and wins over everything, including mid-release.
  always_ff @(posedge clkin) begin
    if (reset) begin
      state_q    <= PLL_RST;
      sync_q     <= 2'b00;
      pulse_q    <= '0;
      filter_q   <= '0;
      timeout_q  <= '0;
      gap_q      <= '0;
      pllReset_q <= 1'b1;
      locked_q   <= 1'b0;
      rstOut_q   <= ALL_ONES;
      retry_q    <= '0;
      loss_q     <= '0;
      fail_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync_q     <= {sync_q[0], pll_lock};
      pulse_q    <= pulse_d;
      filter_q   <= filter_d;
      timeout_q  <= timeout_d;
      gap_q      <= gap_d;
      pllReset_q <= pllReset_d;
      locked_q   <= locked_d;
      rstOut_q   <= rstOut_d;
      retry_q    <= retry_d;
      loss_q     <= loss_d;
      fail_q     <= fail_d;
    end
  end

  assign pll_reset = pllReset_q;
  assign locked    = locked_q;
  assign rst_out   = rstOut_q;
  assign retry_cnt = retry_q;
  assign loss_cnt  = loss_q;
  assign fail      = fail_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// tb_pll_lock_sequencer
// Self-checking bench for pll_lock_sequencer. A phase/elapsed-time reference
// model predicts every output on every cycle. Each scenario task also checks
// the timing relationships it targets against plain arithmetic.
module tb_pll_lock_sequencer;

  localparam int N  = 3;
  localparam int RP = 4;
  localparam int LF = 8;
  localparam int LT = 40;
  localparam int SG = 2;
  localparam int MR = 3;
  localparam int VW = N + 19;

  localparam logic [VW-1:0] RESET_VEC = {1'b1, 1'b0, {N{1'b1}}, 8'd0, 8'd0, 1'b0};

  logic         clkin = 1'b0;
  logic         reset = 1'b1;
  logic         pll_lock = 1'b0;
  logic         pll_reset;
  logic         locked;
  logic [N-1:0] rst_out;
  logic [7:0]   retry_cnt;
  logic [7:0]   loss_cnt;
  logic         fail;

  int errors = 0;
  int checks = 0;
  int cycle  = 0;

  // Model phases: 0 PLL reset pulse, 1 waiting for lock, 2 releasing, 3 running, 4 failed.
  int mMode = 0, mElapsed = 0, mRun = 0, mRel = 0, mRetry = 0, mLoss = 0;
  bit mP1 = 1'b0, mP2 = 1'b0;

  pll_lock_sequencer #(
    .NUM_DOMAINS (N),
    .RESET_PULSE (RP),
    .LOCK_FILTER (LF),
    .LOCK_TIMEOUT(LT),
    .STAGE_GAP   (SG),
    .MAX_RETRY   (MR)
  ) dut (
    .clkin    (clkin),
    .reset    (reset),
    .pll_lock (pll_lock),
    .pll_reset(pll_reset),
    .locked   (locked),
    .rst_out  (rst_out),
    .retry_cnt(retry_cnt),
    .loss_cnt (loss_cnt),
    .fail     (fail)
  );

  always #5 clkin = ~clkin;

  // Advance the reference model by one clock edge using the inputs seen at that edge.
  task automatic modelStep();
    bit ls;
    ls = mP2;
    if (reset) begin
      mMode = 0; mElapsed = 0; mRun = 0; mRel = 0; mRetry = 0; mLoss = 0;
      mP1 = 1'b0; mP2 = 1'b0;
    end else begin
      mP2 = mP1;
      mP1 = pll_lock;
      case (mMode)
        0: begin
          mElapsed++;
          if (mElapsed == RP) begin mMode = 1; mElapsed = 0; mRun = 0; end
        end
        1: begin
          mElapsed++;
          mRun = ls ? mRun + 1 : 0;
          if (mRun == LF) begin
            mMode = 2; mRel = 0;
          end else if (mElapsed == LT) begin
            mRetry++; mElapsed = 0;
            mMode = (mRetry == MR) ? 4 : 0;
          end
        end
        2, 3: begin
          if (!ls) begin
            mMode = 0; mElapsed = 0;
            if (mLoss < 255) mLoss++;
          end else if (mMode == 2) begin
            mRel++;
            if (mRel == (N - 1) * SG) begin mMode = 3; mRetry = 0; end
          end
        end
        default: ;
      endcase
    end
  endtask

  // Expected outputs derived from the model phase; released bits = 1 + elapsed/STAGE_GAP.
  function automatic logic [VW-1:0] expVec();
    logic [N-1:0] r;
    r = '1;
    if (mMode == 2) r = r << (1 + mRel / SG);
    else if (mMode == 3) r = '0;
    return {(mMode == 0 || mMode == 4), (mMode == 2 || mMode == 3), r,
            8'(mRetry), 8'(mLoss), (mMode == 4)};
  endfunction

  function automatic logic [VW-1:0] dutVec();
    return {pll_reset, locked, rst_out, retry_cnt, loss_cnt, fail};
  endfunction

  // Drive inputs just after an edge, then let one edge pass and settle.
  task automatic applyStimulus(input logic rstVal, input logic lockVal);
    reset    = rstVal;
    pll_lock = lockVal;
    @(posedge clkin);
    modelStep();
    cycle++;
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'(($urandom_range(0, 1))));
      if (dutVec() !== RESET_VEC) begin
        errors++;
        $display("[TB] FAIL reset_values t=%0d got=%h exp=%h", cycle, dutVec(), RESET_VEC);
      end
      checks++;
    end
  endtask

  task automatic test_clean_bringup();
    int firstLow = -1, lockEdge = -1, r1Edge = -1, r2Edge = -1;
    applyStimulus(1'b1, 1'b1);
    for (int e = 1; e <= 60; e++) begin
      applyStimulus(1'b0, 1'b1);
      if (dutVec() !== expVec()) begin
        errors++;
        $display("[TB] FAIL bringup_cycle t=%0d got=%h exp=%h", cycle, dutVec(), expVec());
      end
      checks++;
      if (!pll_reset && firstLow < 0) firstLow = e;
      if (locked && !rst_out[0] && lockEdge < 0) lockEdge = e;
      if (!rst_out[1] && r1Edge < 0) r1Edge = e;
      if (!rst_out[2] && r2Edge < 0) r2Edge = e;
      if (r2Edge > 0 && e >= r2Edge + 3) break;
    end
    if (firstLow != RP) begin
      errors++; $display("[TB] FAIL bringup_pll_reset_width got=%0d exp=%0d", firstLow, RP);
    end
    checks++;
    if (lockEdge != RP + LF) begin
      errors++; $display("[TB] FAIL bringup_lock_edge got=%0d exp=%0d", lockEdge, RP + LF);
    end
    checks++;
    if (r1Edge - lockEdge != SG || r2Edge - lockEdge != 2 * SG) begin
      errors++;
      $display("[TB] FAIL bringup_stage_gap got=%0d,%0d exp=%0d,%0d",
               r1Edge - lockEdge, r2Edge - lockEdge, SG, 2 * SG);
    end
    checks++;
    if (retry_cnt !== 8'd0) begin
      errors++; $display("[TB] FAIL bringup_retry got=%0d exp=0", retry_cnt);
    end
    checks++;
  endtask

  task automatic test_chatter();
    int lockEdge = -1;
    logic lockV;
    applyStimulus(1'b1, 1'b0);
    for (int e = 1; e <= 60; e++) begin
      lockV = (e <= 30) ? 1'(((e - 1) / 5) % 2 == 0) : 1'b1;
      applyStimulus(1'b0, lockV);
      if (dutVec() !== expVec()) begin
        errors++;
        $display("[TB] FAIL chatter_cycle t=%0d got=%h exp=%h", cycle, dutVec(), expVec());
      end
      checks++;
      if (locked && lockEdge < 0) lockEdge = e;
    end
    // Final stable high is sampled at edge 31, reaches lock_s two edges later, then LF samples.
    if (lockEdge != 30 + 2 + LF) begin
      errors++; $display("[TB] FAIL chatter_lock_edge got=%0d exp=%0d", lockEdge, 30 + 2 + LF);
    end
    checks++;
    if (retry_cnt !== 8'd0 || fail !== 1'b0) begin
      errors++; $display("[TB] FAIL chatter_no_timeout got=%0d/%b exp=0/0", retry_cnt, fail);
    end
    checks++;
  endtask

  task automatic test_timeout_fail();
    int highCnt = 0, failEdge = -1;
    applyStimulus(1'b1, 1'b0);
    if (pll_reset && !fail) highCnt++;
    for (int e = 1; e <= 3 * (RP + LT) + 40; e++) begin
      applyStimulus(1'b0, (e > 3 * (RP + LT) + 5) ? 1'(($urandom_range(0, 1))) : 1'b0);
      if (dutVec() !== expVec()) begin
        errors++;
        $display("[TB] FAIL timeout_cycle t=%0d got=%h exp=%h", cycle, dutVec(), expVec());
      end
      checks++;
      if (pll_reset && !fail) highCnt++;
      if (fail && failEdge < 0) failEdge = e;
      if (e == RP + LT || e == 2 * (RP + LT) || e == 3 * (RP + LT)) begin
        if (retry_cnt !== 8'(e / (RP + LT))) begin
          errors++;
          $display("[TB] FAIL timeout_retry_step got=%0d exp=%0d", retry_cnt, e / (RP + LT));
        end
        checks++;
      end
    end
    if (highCnt != 3 * RP) begin
      errors++; $display("[TB] FAIL timeout_pulse_cycles got=%0d exp=%0d", highCnt, 3 * RP);
    end
    checks++;
    if (failEdge != 3 * (RP + LT)) begin
      errors++; $display("[TB] FAIL timeout_fail_edge got=%0d exp=%0d", failEdge, 3 * (RP + LT));
    end
    checks++;
    if (!fail || !pll_reset || retry_cnt !== 8'd3 || rst_out !== 3'b111) begin
      errors++;
      $display("[TB] FAIL timeout_sticky got=%b/%b/%0d/%b exp=1/1/3/111", fail, pll_reset, retry_cnt, rst_out);
    end
    checks++;
  endtask

  task automatic test_loss_run();
    int react = -1, highCnt = 0;
    applyStimulus(1'b1, 1'b1);
    for (int e = 1; e <= 40 && mMode != 3; e++) applyStimulus(1'b0, 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1);
    if (rst_out !== 3'b000 || !locked) begin
      errors++; $display("[TB] FAIL lossrun_reached_run got=%b/%b exp=000/1", rst_out, locked);
    end
    checks++;
    for (int r = 1; r <= 40; r++) begin
      applyStimulus(1'b0, (r == 1) ? 1'b0 : 1'b1);
      if (dutVec() !== expVec()) begin
        errors++;
        $display("[TB] FAIL lossrun_cycle t=%0d got=%h exp=%h", cycle, dutVec(), expVec());
      end
      checks++;
      if (rst_out === 3'b111 && !locked && react < 0) react = r;
      if (react > 0 && pll_reset) highCnt++;
    end
    if (react != 3) begin
      errors++; $display("[TB] FAIL lossrun_reaction got=%0d exp=3", react);
    end
    checks++;
    if (loss_cnt !== 8'd1 || highCnt != RP) begin
      errors++; $display("[TB] FAIL lossrun_count got=%0d/%0d exp=1/%0d", loss_cnt, highCnt, RP);
    end
    checks++;
    if (rst_out !== 3'b000 || !locked) begin
      errors++; $display("[TB] FAIL lossrun_resequence got=%b/%b exp=000/1", rst_out, locked);
    end
    checks++;
  endtask

  task automatic test_loss_release();
    logic [N-1:0] prev;
    logic [7:0]   lossBefore;
    int           found = 0, dropLen;
    applyStimulus(1'b1, 1'b1);
    for (int e = 1; e <= 40; e++) begin
      applyStimulus(1'b0, 1'b1);
      if (rst_out === 3'b110) begin found = 1; break; end
    end
    if (!found) begin
      errors++; $display("[TB] FAIL lossrel_wait got=%b exp=110", rst_out);
    end
    checks++;
    lossBefore = loss_cnt;
    prev = rst_out;
    dropLen = $urandom_range(1, 3);
    for (int r = 1; r <= 30; r++) begin
      applyStimulus(1'b0, (r <= dropLen) ? 1'b0 : 1'b1);
      if (dutVec() !== expVec()) begin
        errors++;
        $display("[TB] FAIL lossrel_cycle t=%0d got=%h exp=%h", cycle, dutVec(), expVec());
      end
      checks++;
      if (rst_out !== prev && rst_out !== 3'b111 && rst_out !== (prev << 1)) begin
        errors++; $display("[TB] FAIL lossrel_order got=%b exp_from=%b", rst_out, prev);
      end
      checks++;
      prev = rst_out;
    end
    if (loss_cnt !== lossBefore + 8'd1) begin
      errors++; $display("[TB] FAIL lossrel_count got=%0d exp=%0d", loss_cnt, lossBefore + 8'd1);
    end
    checks++;
  endtask

  task automatic test_reset_mid_release();
    int found = 0;
    applyStimulus(1'b1, 1'b1);
    for (int e = 1; e <= 40; e++) begin
      applyStimulus(1'b0, 1'b1);
      if (rst_out === 3'b100) begin found = 1; break; end
    end
    if (!found) begin
      errors++; $display("[TB] FAIL midrel_wait got=%b exp=100", rst_out);
    end
    checks++;
    applyStimulus(1'b1, 1'b1);
    if (dutVec() !== RESET_VEC) begin
      errors++; $display("[TB] FAIL midrel_reset got=%h exp=%h", dutVec(), RESET_VEC);
    end
    checks++;
  endtask

  task automatic test_random();
    logic lockV, rstV;
    applyStimulus(1'b1, 1'b0);
    for (int e = 0; e < 600; e++) begin
      lockV = ((e / 120) % 2 == 0) ? 1'($urandom_range(0, 15) != 0) : 1'($urandom_range(0, 3) == 0);
      rstV  = 1'($urandom_range(0, 249) == 0);
      applyStimulus(rstV, lockV);
      if (dutVec() !== expVec()) begin
        errors++;
        $display("[TB] FAIL random_cycle t=%0d got=%h exp=%h", cycle, dutVec(), expVec());
      end
      checks++;
    end
  endtask

  task automatic test_saturation();
    int drops = 0, dropLeft = 0, waitLeft = -1, cool = 0, settle = 0;
    logic lockV;
    applyStimulus(1'b1, 1'b1);
    for (int e = 0; e < 15000 && settle < 10; e++) begin
      lockV = (dropLeft > 0) ? 1'b0 : 1'b1;
      if (dropLeft > 0) dropLeft--;
      applyStimulus(1'b0, lockV);
      if (dutVec() !== expVec()) begin
        errors++;
        $display("[TB] FAIL saturation_cycle t=%0d got=%h exp=%h", cycle, dutVec(), expVec());
      end
      checks++;
      if (drops >= 300) settle++;
      else if (cool > 0) cool--;
      else if (waitLeft == 0) begin
        dropLeft = $urandom_range(1, 2); waitLeft = -1; drops++; cool = 6;
      end else if (waitLeft > 0) waitLeft--;
      else if (locked) waitLeft = $urandom_range(0, 3);
    end
    if (drops < 300) begin
      errors++; $display("[TB] FAIL saturation_budget got=%0d exp=300", drops);
    end
    checks++;
    if (loss_cnt !== 8'd255) begin
      errors++; $display("[TB] FAIL saturation_loss_cnt got=%0d exp=255", loss_cnt);
    end
    checks++;
  endtask

  initial begin
    $display("[TB] pll_lock_sequencer bench start");
    test_reset();
    test_clean_bringup();
    test_chatter();
    test_timeout_fail();
    test_loss_run();
    test_loss_release();
    test_reset_mid_release();
    test_random();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
